// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation controller.
//   - Montgomery-unit op codes (square, multiply by M_bar, multiply by 1)
//   - operand memory address map
//   - exponent length and controller state encoding
package rsa_pkg;
  localparam int BITLEN = 1024;

  typedef enum logic [1:0] {
    OPXX = 2'd0,  // x_bar = x_bar * x_bar
    OPXM = 2'd1,  // x_bar = x_bar * M_bar
    OPX1 = 2'd2   // x_bar = x_bar * 1 (out of Montgomery form)
  } mp_op_e;

  localparam logic [1:0] ADDR_XBAR_LO = 2'd0;
  localparam logic [1:0] ADDR_XBAR_HI = 2'd1;
  localparam logic [1:0] ADDR_MBAR_LO = 2'd2;
  localparam logic [1:0] ADDR_MBAR_HI = 2'd3;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_e;
endpackage

// File: rtl/operand_ram.sv
// 4 x DBITS operand memory.
//   wr_en/wr_addr/wr_data : single write port (caller arbitrates)
//   a_en/a_addr/a_data    : registered read port A (held while a_en = 0)
//   b_addr/b_data         : registered read port B (every cycle)
// Addresses beyond the map read as zero and are never written.
// Storage has no reset; only the read registers do.
module operand_ram
  import rsa_pkg::*;
#(
  parameter int DBITS = 512,
  parameter int ABITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [DBITS-1:0] wr_data,
  input  logic             a_en,
  input  logic [ABITS-1:0] a_addr,
  output logic [DBITS-1:0] a_data,
  input  logic [ABITS-1:0] b_addr,
  output logic [DBITS-1:0] b_data
);
  logic [DBITS-1:0] mem [4];

  function automatic logic in_map(input logic [ABITS-1:0] addr);
    return addr <= ABITS'(ADDR_MBAR_HI);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en && in_map(wr_addr)) mem[wr_addr[1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) a_data <= in_map(a_addr) ? mem[a_addr[1:0]] : '0;
      b_data <= in_map(b_addr) ? mem[b_addr[1:0]] : '0;
    end
  end
endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery unit.
//   go/exponent/exp_len       : start request, operands sampled when accepted
//   host_*                    : host access to operand memory while idle
//   mp_start/op_code/count    : one-cycle command to the Montgomery unit
//   mp_rd_* / mp_wr_*         : Montgomery unit memory ports
//   mp_stop                   : unit completion level; its rising edge ends an op
//   busy/done                 : status, done is a one-cycle pulse
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int         DBITS    = 512,
  parameter int         ABITS    = 8,
  parameter logic [9:0] MP_COUNT = 10'd1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [BITLEN-1:0] exponent,
  input  logic [10:0]       exp_len,
  input  logic              host_wr_en,
  input  logic [1:0]        host_addr,
  input  logic [DBITS-1:0]  host_wr_data,
  output logic [DBITS-1:0]  host_rd_data,
  output logic              mp_start,
  output logic [1:0]        mp_op_code,
  output logic [9:0]        mp_count,
  input  logic [ABITS-1:0]  mp_rd_addr,
  output logic [DBITS-1:0]  mp_rd_data,
  input  logic              mp_wr_en,
  input  logic [ABITS-1:0]  mp_wr_addr,
  input  logic [DBITS-1:0]  mp_wr_data,
  input  logic              mp_stop,
  output logic              busy,
  output logic              done
);
  state_e            state;
  mp_op_e            phase;
  logic [BITLEN-1:0] exp_r;
  logic [9:0]        idx;
  logic              stop_q;
  logic              stop_rise;

  // Host is locked out while busy; the Montgomery unit owns the write port then.
  logic             host_wr_ok;
  logic             wr_en;
  logic [ABITS-1:0] wr_addr;
  logic [DBITS-1:0] wr_data;

  assign host_wr_ok = host_wr_en && !busy;
  assign wr_en      = mp_wr_en || host_wr_ok;
  assign wr_addr    = mp_wr_en ? mp_wr_addr : ABITS'(host_addr);
  assign wr_data    = mp_wr_en ? mp_wr_data : host_wr_data;

  operand_ram #(.DBITS(DBITS), .ABITS(ABITS)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .a_en    (!busy),
    .a_addr  (ABITS'(host_addr)),
    .a_data  (host_rd_data),
    .b_addr  (mp_rd_addr),
    .b_data  (mp_rd_data)
  );

  assign mp_count = MP_COUNT;

  // stop_q resets high so a level already present after reset is not an edge.
  assign stop_rise = mp_stop && !stop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= OPXX;
      exp_r      <= '0;
      idx        <= '0;
      stop_q     <= 1'b1;
      mp_start   <= 1'b0;
      mp_op_code <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      stop_q   <= mp_stop;
      mp_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // done is high in the first IDLE cycle, so a go there is dropped.
          if (go && !done) begin
            exp_r <= exponent;
            busy  <= 1'b1;
            state <= ISSUE;
            if (exp_len == 11'd0) begin
              idx   <= '0;
              phase <= OPX1;
            end else begin
              idx   <= 10'(exp_len - 11'd1);
              phase <= OPXX;
            end
          end
        end
        ISSUE: begin
          mp_start   <= 1'b1;
          mp_op_code <= phase;
          state      <= WAIT;
        end
        WAIT: if (stop_rise) state <= NEXT;
        NEXT: begin
          state <= ISSUE;
          if (phase == OPX1) begin
            state <= DONE;
          end else if (phase == OPXX && exp_r[idx]) begin
            phase <= OPXM;
          end else if (idx == '0) begin
            phase <= OPX1;
          end else begin
            idx   <= idx - 10'd1;
            phase <= OPXX;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery responder (stop rises
// 20 cycles after start), op-sequence model from square-and-multiply rules.
module tb_mod_exp_ctrl;
  localparam int DBITS = 512;
  localparam int ABITS = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic [1023:0]     exponent;
  logic [10:0]       exp_len;
  logic              host_wr_en;
  logic [1:0]        host_addr;
  logic [DBITS-1:0]  host_wr_data;
  logic [DBITS-1:0]  host_rd_data;
  logic              mp_start;
  logic [1:0]        mp_op_code;
  logic [9:0]        mp_count;
  logic [ABITS-1:0]  mp_rd_addr;
  logic [DBITS-1:0]  mp_rd_data;
  logic              mp_wr_en;
  logic [ABITS-1:0]  mp_wr_addr;
  logic [DBITS-1:0]  mp_wr_data;
  logic              mp_stop = 1'b1;
  logic              busy;
  logic              done;

  mod_exp_ctrl #(.DBITS(DBITS), .ABITS(ABITS), .MP_COUNT(10'd1023)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .exponent(exponent), .exp_len(exp_len),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data), .mp_start(mp_start), .mp_op_code(mp_op_code),
    .mp_count(mp_count), .mp_rd_addr(mp_rd_addr), .mp_rd_data(mp_rd_data),
    .mp_wr_en(mp_wr_en), .mp_wr_addr(mp_wr_addr), .mp_wr_data(mp_wr_data),
    .mp_stop(mp_stop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int rcnt = 0;
  bit stale = 1'b0;
  logic [1:0] obs[$];
  logic [DBITS-1:0] mm [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Responder and start monitor. In stale mode stop stays high for
  // 10 cycles after start before dropping, so only the later edge is real.
  always @(negedge clk) begin
    if (mp_start) begin
      obs.push_back(mp_op_code);
      last_start = cyc;
      rcnt = 20;
      if (!stale) mp_stop = 1'b0;
    end else if (rcnt > 0) begin
      rcnt = rcnt - 1;
      if (stale && rcnt == 10) mp_stop = 1'b0;
      if (rcnt == 0) mp_stop = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [DBITS-1:0] got, input logic [DBITS-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [1023:0] rnd_exp();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected op stream: for each bit MSB-first square, multiply if bit set;
  // finish with one conversion.
  task automatic run(input logic [1023:0] e, input int len, input bit stale_m, input bit poke);
    logic [1:0] expq[$];
    int cnt, ndone, budget, gap;
    bit seen;
    for (int i = len - 1; i >= 0; i--) begin
      expq.push_back(2'd0);
      if (e[i]) expq.push_back(2'd1);
    end
    expq.push_back(2'd2);
    stale = stale_m;
    obs.delete();
    @(negedge clk);
    exponent = e; exp_len = 11'(len); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cnt = 0; ndone = 0; seen = 1'b0;
    budget = expq.size() * 30 + 50;
    while (!seen && cnt < budget) begin
      @(negedge clk);
      cnt++;
      if (done) begin ndone++; seen = 1'b1; end
      if (poke && cnt == 30) begin
        go = 1'b1; exponent = ~e; exp_len = 11'd5;
        host_wr_en = 1'b1; host_addr = 2'd2; host_wr_data = '1;
      end
      if (poke && cnt == 31) host_wr_en = 1'b0;
      if (!mp_start && obs.size() > 0) chk("op_hold", mp_op_code, obs[obs.size()-1]);
    end
    gap = cyc - last_start;
    // go was still high across the edge where done was high.
    @(negedge clk);
    go = 1'b0;
    chk("done_seen", seen, 1'b1);
    if (stale_m) chk("stale_gap", gap >= 20, 1'b1);
    repeat (30) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("done_pulses", ndone, 1);
    chk("busy_after", busy, 1'b0);
    chk("nops", obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      if (obs[i] !== expq[i]) begin
        chk($sformatf("op[%0d]", i), obs[i], expq[i]);
        break;
      end
    end
  endtask

  initial begin
    logic [1023:0] e;
    int w;
    rst_n = 1'b0; go = 1'b0; exponent = '0; exp_len = '0;
    host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
    mp_rd_addr = '0; mp_wr_en = 1'b0; mp_wr_addr = '0; mp_wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_start", mp_start, 1'b0);
    chk("rst_op", mp_op_code, 2'd0);
    chk("rst_mprd", mp_rd_data, '0);
    chk("rst_hostrd", host_rd_data, '0);
    chk("mp_count", mp_count, 10'd1023);
    rst_n = 1'b1;
    @(negedge clk);

    // Host loads operands while idle.
    mm[0] = {16{$urandom}}; mm[1] = {16{$urandom}};
    mm[2] = {64{8'hA5}};    mm[3] = {64{8'h3C}};
    host_wr_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      host_addr = 2'(a); host_wr_data = mm[a];
      @(negedge clk);
    end
    host_wr_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      host_addr = 2'(a);
      @(negedge clk);
      chk($sformatf("host_rd%0d", a), host_rd_data, mm[a]);
    end

    // Montgomery port: valid write lands, out-of-map write is dropped.
    mp_wr_en = 1'b1; mp_wr_addr = 8'd1; mp_wr_data = {16{$urandom}}; mm[1] = mp_wr_data;
    @(negedge clk);
    mp_wr_addr = 8'd5; mp_wr_data = '1;
    @(negedge clk);
    mp_wr_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      mp_rd_addr = 8'(a);
      @(negedge clk);
      chk($sformatf("mp_rd%0d", a), mp_rd_data, mm[a]);
    end
    mp_rd_addr = 8'd7;
    @(negedge clk);
    chk("mp_rd_oob", mp_rd_data, '0);

    run(1024'hB, 4, 1'b0, 1'b0);
    run('0, 0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) run(rnd_exp(), $urandom_range(1, 24), 1'b0, 1'b0);
    run(rnd_exp(), 12, 1'b0, 1'b1);
    host_addr = 2'd2;
    @(negedge clk);
    @(negedge clk);
    chk("host_wr_busy", host_rd_data, mm[2]);
    run(rnd_exp(), 6, 1'b1, 1'b0);
    run('0, 0, 1'b1, 1'b0);
    e = '0; e[1023] = 1'b1; e[0] = 1'b1;
    run(e, 1024, 1'b0, 1'b0);

    // Reset abandons a sequence mid-wait.
    stale = 1'b0; obs.delete();
    @(negedge clk);
    exponent = rnd_exp(); exp_len = 11'd8; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    w = 0;
    while (obs.size() < 3 && w < 500) begin @(negedge clk); w++; end
    chk("rst_reach", obs.size() >= 3, 1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_start", mp_start, 1'b0);
    chk("midrst_done", done, 1'b0);
    rst_n = 1'b1;
    obs.delete();
    repeat (60) @(negedge clk);
    chk("midrst_nostart", obs.size(), 0);
    chk("midrst_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
